note_sequencer: RTL and testbench

NOTE_SEQUENCER -- requirements
Module: note_sequencer

---
 rtl/note_sequencer_pkg.sv | 34 +++
 rtl/note_rom.sv | 16 +
 rtl/note_sequencer.sv | 131 +++++++++++++
 tb/tb_note_sequencer.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/note_sequencer_pkg.sv
// rtl/note_sequencer_pkg.sv - shared state encoding, entry layout and defaults for the note sequencer
package note_sequencer_pkg;

    localparam int DEFAULT_NUM_NOTES = 32;
    localparam int DEFAULT_GAP_CLKS  = 12000;
    localparam int ROM_DEPTH         = 32;
    localparam int ENTRY_W           = 32;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_OFFER = 3'd2,
        ST_PLAY  = 3'd3,
        ST_GAP   = 3'd4
    } seq_state_t;

    typedef struct packed {
        logic [15:0] halfperiod;
        logic [15:0] cycles;
    } note_entry_t;

    // Short arpeggio at 12 MHz, ending on a cycles=0 terminator.
    function automatic logic [ROM_DEPTH*ENTRY_W-1:0] default_melody();
        logic [ROM_DEPTH*ENTRY_W-1:0] rom;
        rom = '0;
        rom[0*ENTRY_W +: ENTRY_W] = {16'd13636, 16'd110};
        rom[1*ENTRY_W +: ENTRY_W] = {16'd11467, 16'd131};
        rom[2*ENTRY_W +: ENTRY_W] = {16'd9101,  16'd165};
        rom[3*ENTRY_W +: ENTRY_W] = {16'd0,     16'd50};
        rom[4*ENTRY_W +: ENTRY_W] = {16'd7653,  16'd392};
        return rom;
    endfunction

endpackage

// File: rtl/note_rom.sv
// rtl/note_rom.sv - melody table with synchronous read and one clock of latency
module note_rom
    import note_sequencer_pkg::*;
#(
    parameter logic [ROM_DEPTH*ENTRY_W-1:0] INIT = default_melody()
) (
    input  logic               hwclk,
    input  logic [4:0]         addr,
    output logic [ENTRY_W-1:0] data
);

    always_ff @(posedge hwclk) begin
        data <= INIT[{addr, 5'd0} +: ENTRY_W];
    end

endmodule

// File: rtl/note_sequencer.sv
// rtl/note_sequencer.sv - steps through the melody table and hands notes to a tone generator
module note_sequencer
    import note_sequencer_pkg::*;
#(
    parameter int                            NUM_NOTES = DEFAULT_NUM_NOTES,
    parameter int                            GAP_CLKS  = DEFAULT_GAP_CLKS,
    parameter logic [ROM_DEPTH*ENTRY_W-1:0]  ROM_INIT  = default_melody()
) (
    input  logic        hwclk,
    input  logic        rst,
    input  logic        start,
    input  logic        stop,
    input  logic        loop_en,
    output logic [15:0] note_halfperiod,
    output logic [15:0] note_cycles,
    output logic        note_valid,
    input  logic        note_ready,
    input  logic        note_done,
    output logic        busy,
    output logic [4:0]  note_index,
    output logic [7:0]  led
);

    localparam logic [4:0]  LAST_INDEX = 5'(NUM_NOTES - 1);
    localparam logic [15:0] GAP_LOAD   = 16'(GAP_CLKS);
    localparam bit          NO_GAP     = (GAP_CLKS == 0);

    seq_state_t        state;
    seq_state_t        state_next;
    logic [4:0]        index_next;
    logic [15:0]       gap_cnt;
    logic [15:0]       gap_next;
    logic              load_note;
    logic              advance;
    logic [ENTRY_W-1:0] rom_data;
    note_entry_t       fetched;

    // The ROM is addressed with the next index so the entry is already on rom_data during FETCH.
    note_rom #(
        .INIT (ROM_INIT)
    ) u_rom (
        .hwclk (hwclk),
        .addr  (index_next),
        .data  (rom_data)
    );

    assign fetched = rom_data;

    always_ff @(posedge hwclk) begin
        if (rst) begin
            state           <= ST_IDLE;
            note_index      <= '0;
            gap_cnt         <= '0;
            note_halfperiod <= '0;
            note_cycles     <= '0;
        end else begin
            state      <= state_next;
            note_index <= index_next;
            gap_cnt    <= gap_next;
            if (load_note) begin
                note_halfperiod <= fetched.halfperiod;
                note_cycles     <= fetched.cycles;
            end
        end
    end

    always_comb begin
        state_next = state;
        index_next = note_index;
        gap_next   = gap_cnt;
        load_note  = 1'b0;
        advance    = 1'b0;
        if (stop) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state_next = ST_FETCH;
                        index_next = '0;
                    end
                end
                ST_FETCH: begin
                    if (fetched.cycles == 16'd0) begin
                        state_next = ST_IDLE;
                    end else begin
                        state_next = ST_OFFER;
                        load_note  = 1'b1;
                    end
                end
                ST_OFFER: begin
                    if (note_ready) state_next = ST_PLAY;
                end
                ST_PLAY: begin
                    if (note_done) begin
                        if (NO_GAP) begin
                            advance = 1'b1;
                        end else begin
                            state_next = ST_GAP;
                            gap_next   = GAP_LOAD;
                        end
                    end
                end
                ST_GAP: begin
                    gap_next = gap_cnt - 16'd1;
                    if (gap_cnt == 16'd1) advance = 1'b1;
                end
                default: state_next = ST_IDLE;
            endcase
            // loop_en only matters here, at the end-of-note decision.
            if (advance) begin
                if (note_index < LAST_INDEX) begin
                    index_next = note_index + 5'd1;
                    state_next = ST_FETCH;
                end else if (loop_en) begin
                    index_next = '0;
                    state_next = ST_FETCH;
                end else begin
                    state_next = ST_IDLE;
                end
            end
        end
    end

    always_comb begin
        busy       = (state != ST_IDLE);
        note_valid = (state == ST_OFFER);
        led        = {note_valid, loop_en, busy, note_index};
    end

endmodule

// File: tb/tb_note_sequencer.sv
// tb/tb_note_sequencer.sv - directed bench for note_sequencer with a behavioural playback model
`timescale 1ns/1ps
module tb_note_sequencer;

    logic hwclk = 1'b0;
    always #5 hwclk = ~hwclk;

    logic [1:0]  rst, start, stop, loop_en, ready, done;
    logic [1:0]  valid, busy;
    logic [15:0] hp  [2];
    logic [15:0] cyc [2];
    logic [4:0]  idx [2];
    logic [7:0]  led [2];

    // Instance 0: two notes with a 4-clock gap. Instance 1: no gap, rest first, terminator at entry 2.
    localparam logic [1023:0] ROM_A = {{29{32'h0}}, 32'h0000_0000, 32'h1234_0020, 32'h5EE3_0010};
    localparam logic [1023:0] ROM_B = {{29{32'h0}}, 32'h7777_0000, 32'h0ABC_0003, 32'h0000_0005};

    note_sequencer #(.NUM_NOTES(2), .GAP_CLKS(4), .ROM_INIT(ROM_A)) dut_a (
        .hwclk(hwclk), .rst(rst[0]), .start(start[0]), .stop(stop[0]), .loop_en(loop_en[0]),
        .note_halfperiod(hp[0]), .note_cycles(cyc[0]), .note_valid(valid[0]),
        .note_ready(ready[0]), .note_done(done[0]), .busy(busy[0]),
        .note_index(idx[0]), .led(led[0])
    );

    note_sequencer #(.NUM_NOTES(4), .GAP_CLKS(0), .ROM_INIT(ROM_B)) dut_b (
        .hwclk(hwclk), .rst(rst[1]), .start(start[1]), .stop(stop[1]), .loop_en(loop_en[1]),
        .note_halfperiod(hp[1]), .note_cycles(cyc[1]), .note_valid(valid[1]),
        .note_ready(ready[1]), .note_done(done[1]), .busy(busy[1]),
        .note_index(idx[1]), .led(led[1])
    );

    int tests = 0;
    int fails = 0;
    bit armed = 1'b0;

    // Model: playback phase per instance (0 idle, 1 fetch, 2 offer, 3 play, 4 gap).
    logic [31:0] tbl [2][32];
    int          nn   [2] = '{2, 4};
    int          gapc [2] = '{4, 0};
    int          phase [2] = '{0, 0};
    int          gap_left [2] = '{0, 0};
    int          m_idx [2] = '{0, 0};
    logic [15:0] m_hp  [2] = '{16'h0, 16'h0};
    logic [15:0] m_cyc [2] = '{16'h0, 16'h0};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic model_step(input int d);
        logic [31:0] e;
        bit adv;
        adv = 1'b0;
        if (rst[d]) begin
            phase[d] = 0; m_idx[d] = 0; m_hp[d] = 16'h0; m_cyc[d] = 16'h0;
        end else if (stop[d]) begin
            phase[d] = 0;
        end else begin
            case (phase[d])
                0: if (start[d]) begin phase[d] = 1; m_idx[d] = 0; end
                1: begin
                    e = tbl[d][m_idx[d]];
                    if (e[15:0] == 16'h0) phase[d] = 0;
                    else begin m_hp[d] = e[31:16]; m_cyc[d] = e[15:0]; phase[d] = 2; end
                end
                2: if (ready[d]) phase[d] = 3;
                3: if (done[d]) begin
                    if (gapc[d] == 0) adv = 1'b1;
                    else begin phase[d] = 4; gap_left[d] = gapc[d]; end
                end
                default: begin
                    gap_left[d] = gap_left[d] - 1;
                    if (gap_left[d] == 0) adv = 1'b1;
                end
            endcase
            if (adv) begin
                if (m_idx[d] < nn[d] - 1) begin m_idx[d] = m_idx[d] + 1; phase[d] = 1; end
                else if (loop_en[d]) begin m_idx[d] = 0; phase[d] = 1; end
                else phase[d] = 0;
            end
        end
    endtask

    initial forever begin
        @(posedge hwclk);
        for (int d = 0; d < 2; d++) model_step(d);
    end

    initial forever begin
        @(negedge hwclk);
        if (armed) begin
            for (int d = 0; d < 2; d++) begin
                check($sformatf("model_busy%0d", d), 32'(busy[d]), 32'(phase[d] != 0));
                check($sformatf("model_valid%0d", d), 32'(valid[d]), 32'(phase[d] == 2));
                check($sformatf("model_index%0d", d), 32'(idx[d]), 32'(m_idx[d]));
                check($sformatf("model_halfperiod%0d", d), 32'(hp[d]), 32'(m_hp[d]));
                check($sformatf("model_cycles%0d", d), 32'(cyc[d]), 32'(m_cyc[d]));
                check($sformatf("model_led%0d", d), 32'(led[d]),
                      32'({(phase[d] == 2), loop_en[d], (phase[d] != 0), 5'(m_idx[d])}));
            end
        end
    end

    task automatic tick();
        @(posedge hwclk);
        #1;
    endtask

    task automatic wait_valid(input int d, output int n);
        n = 0;
        while (!valid[d] && n < 40) begin tick(); n++; end
    endtask

    task automatic wait_idle(input int d, output int n, output bit saw_valid);
        n = 0;
        saw_valid = 1'b0;
        while (busy[d] && n < 40) begin
            tick(); n++;
            if (valid[d]) saw_valid = 1'b1;
        end
    endtask

    initial begin
        int n;
        bit sv;
        logic [1023:0] ra, rb;
        ra = ROM_A;
        rb = ROM_B;
        for (int i = 0; i < 32; i++) begin
            tbl[0][i] = ra[i*32 +: 32];
            tbl[1][i] = rb[i*32 +: 32];
        end
        rst = 2'b11; start = '0; stop = '0; loop_en = '0; ready = '0; done = '0;
        tick(); tick();
        armed = 1'b1;
        check("rst_busy", 32'(busy[0]), 32'h0);
        check("rst_led", 32'(led[0]), 32'h00);
        check("rst_halfperiod", 32'(hp[0]), 32'h0);
        rst = 2'b00;

        // Normal play with ready already high
        ready[0] = 1'b1; start[0] = 1'b1; tick(); start[0] = 1'b0;
        check("fetch_valid", 32'(valid[0]), 32'h0);
        check("fetch_busy", 32'(busy[0]), 32'h1);
        tick();
        check("offer_valid", 32'(valid[0]), 32'h1);
        check("offer_halfperiod", 32'(hp[0]), 32'h5EE3);
        check("offer_cycles", 32'(cyc[0]), 32'h0010);
        tick();
        check("play_valid", 32'(valid[0]), 32'h0);

        // Gap then backpressure on entry 1; a stray done in OFFER is ignored
        ready[0] = 1'b0; done[0] = 1'b1; tick(); done[0] = 1'b0;
        wait_valid(0, n);
        check("gap_to_offer_clks", 32'(n), 32'd5);
        check("entry1_index", 32'(idx[0]), 32'd1);
        for (int k = 1; k < 5; k++) begin
            done[0] = (k == 2);
            tick();
            done[0] = 1'b0;
            check("hold_valid", 32'(valid[0]), 32'h1);
            check("hold_halfperiod", 32'(hp[0]), 32'h1234);
            check("hold_cycles", 32'(cyc[0]), 32'h0020);
        end
        ready[0] = 1'b1; tick();
        check("handshake_valid", 32'(valid[0]), 32'h0);
        check("handshake_busy", 32'(busy[0]), 32'h1);

        // Last entry without loop: gap then idle
        done[0] = 1'b1; tick(); done[0] = 1'b0;
        wait_idle(0, n, sv);
        check("end_gap_clks", 32'(n), 32'd4);
        check("end_no_valid", 32'(sv), 32'h0);
        check("end_index", 32'(idx[0]), 32'd1);
        check("end_led", 32'(led[0]), 32'h01);

        // Loop wraps from entry 1 to entry 0
        loop_en[0] = 1'b1; start[0] = 1'b1; tick(); start[0] = 1'b0;
        tick(); tick();
        done[0] = 1'b1; tick(); done[0] = 1'b0;
        wait_valid(0, n);
        check("loop_entry1_clks", 32'(n), 32'd5);
        tick();
        done[0] = 1'b1; tick(); done[0] = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        check("wrap_index", 32'(idx[0]), 32'd0);
        check("wrap_busy", 32'(busy[0]), 32'h1);
        check("wrap_fetch_valid", 32'(valid[0]), 32'h0);
        tick();
        check("wrap_offer_halfperiod", 32'(hp[0]), 32'h5EE3);
        tick();

        // Abort in PLAY of entry 1 with start and done in the same cycle
        done[0] = 1'b1; tick(); done[0] = 1'b0;
        wait_valid(0, n);
        tick();
        stop[0] = 1'b1; start[0] = 1'b1; done[0] = 1'b1; tick();
        stop[0] = 1'b0; start[0] = 1'b0; done[0] = 1'b0;
        check("abort_busy", 32'(busy[0]), 32'h0);
        check("abort_valid", 32'(valid[0]), 32'h0);
        check("abort_index", 32'(idx[0]), 32'd1);
        tick();
        check("abort_led", 32'(led[0]), 32'h41);

        // Reset while offering entry 1
        loop_en[0] = 1'b0; start[0] = 1'b1; tick(); start[0] = 1'b0;
        tick(); tick();
        ready[0] = 1'b0; done[0] = 1'b1; tick(); done[0] = 1'b0;
        wait_valid(0, n);
        check("pre_rst_index", 32'(idx[0]), 32'd1);
        rst[0] = 1'b1; start[0] = 1'b1; ready[0] = 1'b1; tick();
        rst[0] = 1'b0; start[0] = 1'b0;
        check("rst_offer_led", 32'(led[0]), 32'h00);
        check("rst_offer_halfperiod", 32'(hp[0]), 32'h0);
        check("rst_offer_cycles", 32'(cyc[0]), 32'h0);
        check("rst_offer_index", 32'(idx[0]), 32'd0);

        // No-gap instance: rest, direct advance, terminator
        ready[1] = 1'b1; start[1] = 1'b1; tick(); start[1] = 1'b0;
        tick();
        check("rest_valid", 32'(valid[1]), 32'h1);
        check("rest_halfperiod", 32'(hp[1]), 32'h0000);
        check("rest_cycles", 32'(cyc[1]), 32'h0005);
        tick();
        done[1] = 1'b1; tick(); done[1] = 1'b0;
        wait_valid(1, n);
        check("nogap_clks", 32'(n), 32'd1);
        check("nogap_halfperiod", 32'(hp[1]), 32'h0ABC);
        tick();
        done[1] = 1'b1; tick(); done[1] = 1'b0;
        check("term_fetch_busy", 32'(busy[1]), 32'h1);
        wait_idle(1, n, sv);
        check("term_clks", 32'(n), 32'd1);
        check("term_no_valid", 32'(sv), 32'h0);
        check("term_index", 32'(idx[1]), 32'd2);

        tick(); tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
